mem_port_arbiter: RTL and testbench

Two-requester arbiter that time-shares the single-port 10-bit image/program memory (20-bit address, registered read on posedge, write on negedge) between the processor core (port 0) and the image loader/readback engine (port 1). Ownership is granted per-cycle with a bounded burst length and an optional lock for atomic read-modify-write. The block sits between both requesters and the memory's `RoW`/`Address`/`DataIn`/`DataOut` pins and generates per-port read-valid strobes aligned to the memory's one-cycle read latency.

---
 rtl/mem_port_arbiter.sv | 82 ++++++++
 tb/tb_mem_port_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter time-sharing a single-port memory between the core (port 0)
// and the loader (port 1), with bounded bursts, lock for RMW, and read-valid tracking.
module mem_port_arbiter #(
  parameter int BURST = 4,
  parameter int AW    = 20,
  parameter int DW    = 10
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          rw0,
  input  logic          rw1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_row,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [3:0] CNT_MAX = 4'(BURST - 1);

  logic       r_owner;
  logic [3:0] r_cnt;
  logic [1:0] r_rd_pend;

  logic w_req_o;
  logic w_req_x;
  logic w_lock_o;
  logic w_rw_o;

  assign w_req_o  = r_owner ? req1  : req0;
  assign w_req_x  = r_owner ? req0  : req1;
  assign w_lock_o = r_owner ? lock1 : lock0;
  assign w_rw_o   = r_owner ? rw1   : rw0;

  // Only the current owner can ever be granted; the other port waits for handover.
  assign gnt0 = ~r_owner & req0;
  assign gnt1 =  r_owner & req1;

  assign mem_addr = r_owner ? addr1  : addr0;
  assign mem_din  = r_owner ? wdata1 : wdata0;
  assign mem_row  = w_req_o & w_rw_o;

  assign rvalid0 = r_rd_pend[0];
  assign rvalid1 = r_rd_pend[1];
  assign rdata0  = mem_dout;
  assign rdata1  = mem_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner   <= 1'b0;
      r_cnt     <= '0;
      r_rd_pend <= '0;
    end else begin
      r_rd_pend <= {gnt1 & ~rw1, gnt0 & ~rw0};
      if (w_req_o && w_lock_o) begin
        r_cnt <= r_cnt;
      end else if (w_req_x && (!w_req_o || r_cnt == CNT_MAX)) begin
        r_owner <= ~r_owner;
        r_cnt   <= '0;
      end else if (w_req_o) begin
        // Saturate so a lone requester keeps streaming until contention appears.
        r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 4'd1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural single-port memory plus a per-cycle
// vector table and a hand-written reset-during-read sequence.
module tb_mem_port_arbiter;

  localparam int AW = 20;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 0, req1 = 0, rw0 = 0, rw1 = 0, lock0 = 0, lock1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_row;
  logic [DW-1:0] rdata0, rdata1, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.BURST(4), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_row(mem_row), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_dout <= mem[mem_addr];
  always @(negedge clk) if (mem_row) mem[mem_addr] <= mem_din;

  typedef struct {
    logic          rst;
    logic          r0, w0, l0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1, l1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          g0, g1, v0, v1;
    logic [DW-1:0] rd0, rd1;
    logic          row;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int rst, int r0, int w0, int l0, int a0, int d0,
                              int r1, int w1, int l1, int a1, int d1,
                              int g0, int g1, int v0, int v1, int rd0, int rd1, int row);
    vec_t v;
    v.rst = 1'(rst); v.r0 = 1'(r0); v.w0 = 1'(w0); v.l0 = 1'(l0);
    v.a0 = AW'(a0); v.d0 = DW'(d0);
    v.r1 = 1'(r1); v.w1 = 1'(w1); v.l1 = 1'(l1);
    v.a1 = AW'(a1); v.d1 = DW'(d1);
    v.g0 = 1'(g0); v.g1 = 1'(g1); v.v0 = 1'(v0); v.v1 = 1'(v1);
    v.rd0 = DW'(rd0); v.rd1 = DW'(rd1); v.row = 1'(row);
    return v;
  endfunction

  task automatic chk(input string name, input int step, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d want %0d", name, step, act, exp);
    end
  endtask

  initial begin
    mem[1013] = 10'd128;
    mem[500]  = 10'd18;

    // idle / read 1013 / write 17408 then readback on port 1
    vecs.push_back(mk(1, 1,0,0,1013,0,   0,0,0,0,0,       1,0,0,0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,0,0,      0,0,0,0,0,       0,0,1,0,128,0,0));
    vecs.push_back(mk(1, 0,0,0,0,0,      1,1,0,17408,214, 0,0,0,0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,0,0,      1,1,0,17408,214, 0,1,0,0,0,0,1));
    vecs.push_back(mk(1, 0,0,0,0,0,      1,0,0,17408,0,   0,1,0,0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,0,0,      0,0,0,0,0,       0,0,0,1,0,214,0));
    // reset, then contended reads: 4 grants each, no gap
    vecs.push_back(mk(0, 0,0,0,0,0,      0,0,0,0,0,       0,0,0,0,0,0,0));
    vecs.push_back(mk(1, 1,0,0,1013,0,   1,0,0,17408,0,   1,0,0,0,0,0,0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 1,0,0,1013,0, 1,0,0,17408,0,   1,0,1,0,128,0,0));
    vecs.push_back(mk(1, 1,0,0,1013,0,   1,0,0,17408,0,   0,1,1,0,128,0,0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 1,0,0,1013,0, 1,0,0,17408,0,   0,1,0,1,0,214,0));
    vecs.push_back(mk(1, 1,0,0,1013,0,   1,0,0,17408,0,   1,0,0,1,0,214,0));
    vecs.push_back(mk(1, 0,0,0,0,0,      0,0,0,0,0,       0,0,1,0,128,0,0));
    // lock0 holds port 0 for 10 accesses against a waiting port 1
    vecs.push_back(mk(1, 1,0,1,1013,0,   1,0,0,17408,0,   1,0,0,0,0,0,0));
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(1, 1,0,1,1013,0, 1,0,0,17408,0,   1,0,1,0,128,0,0));
    vecs.push_back(mk(1, 0,0,0,0,0,      1,0,0,17408,0,   0,0,1,0,128,0,0));
    vecs.push_back(mk(1, 0,0,0,0,0,      1,0,0,17408,0,   0,1,0,0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,0,0,      0,0,0,0,0,       0,0,0,1,0,214,0));
    // reset, then simultaneous write/read of 1017
    vecs.push_back(mk(0, 0,0,0,0,0,      0,0,0,0,0,       0,0,0,0,0,0,0));
    vecs.push_back(mk(1, 1,1,0,1017,5,   1,0,0,1017,0,    1,0,0,0,0,0,1));
    vecs.push_back(mk(1, 0,0,0,0,0,      1,0,0,1017,0,    0,0,0,0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,0,0,      1,0,0,1017,0,    0,1,0,0,0,0,0));
    vecs.push_back(mk(1, 0,0,0,0,0,      0,0,0,0,0,       0,0,0,1,0,5,0));

    // reset state
    addr0 = 20'd123; wdata0 = 10'd7;
    @(negedge clk);
    chk("rst_gnt0", -1, int'(gnt0), 0);
    chk("rst_gnt1", -1, int'(gnt1), 0);
    chk("rst_rvalid0", -1, int'(rvalid0), 0);
    chk("rst_rvalid1", -1, int'(rvalid1), 0);
    chk("rst_mem_row", -1, int'(mem_row), 0);
    chk("rst_mem_addr", -1, int'(mem_addr), 123);
    chk("rst_mem_din", -1, int'(mem_din), 7);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      rst_n = vecs[i].rst;
      req0 = vecs[i].r0; rw0 = vecs[i].w0; lock0 = vecs[i].l0;
      addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
      req1 = vecs[i].r1; rw1 = vecs[i].w1; lock1 = vecs[i].l1;
      addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
      @(negedge clk);
      chk("gnt0", i, int'(gnt0), int'(vecs[i].g0));
      chk("gnt1", i, int'(gnt1), int'(vecs[i].g1));
      chk("rvalid0", i, int'(rvalid0), int'(vecs[i].v0));
      chk("rvalid1", i, int'(rvalid1), int'(vecs[i].v1));
      chk("mem_row", i, int'(mem_row), int'(vecs[i].row));
      if (vecs[i].v0) chk("rdata0", i, int'(rdata0), int'(vecs[i].rd0));
      if (vecs[i].v1) chk("rdata1", i, int'(rdata1), int'(vecs[i].rd1));
    end

    // port 1 owns after the last table step; read 500, then reset before the next edge
    @(posedge clk); #1;
    req1 = 1'b1; rw1 = 1'b0; addr1 = 20'd500;
    @(negedge clk);
    chk("mid_gnt1", 100, int'(gnt1), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rvalid1_async", 101, int'(rvalid1), 0);
    req1 = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rvalid1_after", 102, int'(rvalid1), 0);
    req0 = 1'b1; rw0 = 1'b0; addr0 = 20'd500;
    @(negedge clk);
    chk("mid_owner0_gnt0", 103, int'(gnt0), 1);
    chk("mid_owner0_addr", 104, int'(mem_addr), 500);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    chk("mid_rvalid0", 105, int'(rvalid0), 1);
    chk("mid_rdata0", 106, int'(rdata0), 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
